// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and widths for the FIFO input arbiter slice.
//   arb_state_e : arbiter FSM state (IDLE, GRANT)
//   DATA_W      : width of each requester / FIFO data word
//   STATS_W     : width of each per-requester beat counter (ARB_STATS_EN builds)
//   BURST_CNT_W : width of the beats-in-current-grant counter
`timescale 1ns/1ps
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int DATA_W      = 32;
    localparam int STATS_W     = 16;
    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/fifo_in_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first asserted request
//   searching last+1, last+2, ... wrapping modulo NUM_REQ, so the previous
//   owner is considered last.
//   Ports:
//     req   in  NUM_REQ  request vector
//     last  in  IDX_W    index of the previous owner
//     found out 1        any request asserted
//     idx   out IDX_W    chosen index (0 when found=0)
`timescale 1ns/1ps
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_in_arbiter.sv
// fifo_in_arbiter
//   Round-robin arbiter sharing the FIFO data_in valid/ready port among
//   NUM_REQ producers. A grant is locked for up to MAX_BURST beats and the
//   owner's stream is passed through combinationally (zero latency). Each
//   grant costs exactly one IDLE bubble cycle.
//   Optional feature macro: ARB_STATS_EN adds per-requester beat counters.
//   Ports:
//     clk          in   1             clock
//     rst          in   1             async active-high reset
//     req_data     in   NUM_REQ*32    requester i data at [32*i +: 32]
//     req_vld      in   NUM_REQ       requester valids
//     req_rdy      out  NUM_REQ       requester readys
//     data_out     out  32            to FIFO data_in
//     data_out_vld out  1             to FIFO data_in_vld
//     data_out_rdy in   1             from FIFO data_in_rdy
//     grant_id     out  clog2(NUM_REQ) current owner, valid when busy=1
//     busy         out  1             1 while in GRANT
//     stats_clr    in   1             (ARB_STATS_EN) sync clear of counters
//     stats_cnt    out  NUM_REQ*16    (ARB_STATS_EN) saturating beat counts
//
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin, bubble cycle
//   GRANT | owner's stream passed through until burst end or vld drop
`timescale 1ns/1ps
module fifo_in_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_out_vld,
    input  logic                         data_out_rdy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef ARB_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [NUM_REQ*STATS_W-1:0]   stats_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       last_owner;
    logic [BURST_CNT_W-1:0] beat_cnt;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   owner_vld;
    logic                   beat;
    logic                   burst_end;
    logic                   release_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_vld),
        .last  (last_owner),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_vld     = req_vld[owner];
    assign beat          = (state == GRANT) && owner_vld && data_out_rdy;
    assign burst_end     = beat && (beat_cnt == BURST_CNT_W'(MAX_BURST - 1));
    // A dropped valid ends the grant; backpressure alone never does.
    assign release_grant = (state == GRANT) && (burst_end || !owner_vld);

    always_comb begin
        data_out     = '0;
        data_out_vld = 1'b0;
        req_rdy      = '0;
        if (state == GRANT) begin
            data_out       = req_data[DATA_W*owner +: DATA_W];
            data_out_vld   = owner_vld;
            req_rdy[owner] = data_out_rdy;
        end
    end

    assign busy     = (state == GRANT);
    assign grant_id = owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        beat_cnt   <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [STATS_W-1:0] stats_q [NUM_REQ];

    // Clear has priority over a coincident beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) stats_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr)
                    stats_q[i] <= '0;
                else if (beat && (owner == IDX_W'(i)) && (stats_q[i] != '1))
                    stats_q[i] <= stats_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stats_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) stats_cnt[STATS_W*i +: STATS_W] = stats_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_in_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_in_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  req_data;
    logic [3:0]    req_vld;
    logic [3:0]    req_rdy;
    logic [31:0]   data_out;
    logic          data_out_vld;
    logic          data_out_rdy;
    logic [1:0]    grant_id;
    logic          busy;
`ifdef ARB_STATS_EN
    logic          stats_clr;
    logic [63:0]   stats_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int seq [4];

    always #5 clk = ~clk;

    fifo_in_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_data     (req_data),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .data_out_rdy (data_out_rdy),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .stats_cnt    (stats_cnt)
`endif
    );

    function automatic logic [31:0] exp_d(input int r, input int n);
        return {r[7:0], n[23:0]};
    endfunction

    // Producers: each advances its sequence number when its beat is accepted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) seq[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (req_vld[i] && req_rdy[i]) seq[i] <= seq[i] + 1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = exp_d(i, seq[i]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        busy;
        logic [1:0]  gid;
        logic        vld;
        logic [3:0]  rdy;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [25];

    initial begin
        int k;
        int nb;
        bit done;

        // Round-robin table: 5 grants (0,1,2,3,0), each an IDLE bubble + 4 beats.
        k = 0;
        for (int g = 0; g < 5; g++) begin
            tbl[k].busy = 1'b0; tbl[k].gid = 2'd0; tbl[k].vld = 1'b0;
            tbl[k].rdy  = 4'b0000; tbl[k].data = 32'h0;
            k++;
            for (int b = 0; b < 4; b++) begin
                tbl[k].busy = 1'b1;
                tbl[k].gid  = 2'(g % 4);
                tbl[k].vld  = 1'b1;
                tbl[k].rdy  = 4'(1 << (g % 4));
                tbl[k].data = exp_d(g % 4, (g / 4) * 4 + b);
                k++;
            end
        end

        rst          = 1'b1;
        req_vld      = 4'b1111;
        data_out_rdy = 1'b1;
`ifdef ARB_STATS_EN
        stats_clr    = 1'b0;
`endif

        // Reset held with every requester valid.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(data_out_vld), 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);

        // All four valid continuously, rdy=1.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("rr%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("rr%0d_vld", i), 32'(data_out_vld), 32'(tbl[i].vld));
            chk($sformatf("rr%0d_rdy", i), 32'(req_rdy), 32'(tbl[i].rdy));
            if (tbl[i].busy) chk($sformatf("rr%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
            if (tbl[i].vld)  chk($sformatf("rr%0d_data", i), data_out, tbl[i].data);
        end

        // Only req 2: two beats, drop valid, re-raise.
        do_reset();
        req_vld = 4'b0100;
        #1 chk("r2_idle", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("r2_gid", 32'(grant_id), 32'd2);
        chk("r2_rdy", 32'(req_rdy), 32'b0100);
        chk("r2_d0", data_out, exp_d(2, 0));
        @(negedge clk); #1;
        chk("r2_d1", data_out, exp_d(2, 1));
        @(negedge clk);
        req_vld = 4'b0000;
        #1;
        chk("r2_drop_busy", 32'(busy), 32'd1);
        chk("r2_drop_vld", 32'(data_out_vld), 32'd0);
        @(negedge clk);
        req_vld = 4'b0100;
        #1 chk("r2_rel", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("r2_regrant_busy", 32'(busy), 32'd1);
        chk("r2_regrant_gid", 32'(grant_id), 32'd2);
        chk("r2_d2", data_out, exp_d(2, 2));

        // Backpressure for 10 cycles mid-burst on req 1.
        do_reset();
        req_vld = 4'b0010;
        #1 chk("bp_idle", 32'(busy), 32'd0);
        @(negedge clk); #1 chk("bp_d0", data_out, exp_d(1, 0));
        @(negedge clk); #1 chk("bp_d1", data_out, exp_d(1, 1));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            data_out_rdy = 1'b0;
            #1;
            chk($sformatf("bp_hold%0d_busy", c), 32'(busy), 32'd1);
            chk($sformatf("bp_hold%0d_gid", c), 32'(grant_id), 32'd1);
            chk($sformatf("bp_hold%0d_data", c), data_out, exp_d(1, 2));
            chk($sformatf("bp_hold%0d_rdy", c), 32'(req_rdy), 32'd0);
        end
        @(negedge clk);
        data_out_rdy = 1'b1;
        #1 chk("bp_d2", data_out, exp_d(1, 2));
        @(negedge clk); #1;
        chk("bp_d3", data_out, exp_d(1, 3));
        chk("bp_d3_busy", 32'(busy), 32'd1);
        @(negedge clk); #1 chk("bp_rel", 32'(busy), 32'd0);

        // Reset mid-burst after the 2nd beat of a grant to req 1.
        do_reset();
        req_vld = 4'b0010;
        @(negedge clk); #1 chk("mr_gid", 32'(grant_id), 32'd1);
        @(negedge clk); #1 chk("mr_d1", data_out, exp_d(1, 1));
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 4'b0011;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_vld", 32'(data_out_vld), 32'd0);
        chk("mr_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mr_idle", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("mr_next_busy", 32'(busy), 32'd1);
        chk("mr_next_gid", 32'(grant_id), 32'd0);
        chk("mr_next_data", data_out, exp_d(0, 0));

`ifdef ARB_STATS_EN
        do_reset();
        #1 chk("st_rst", 32'(stats_cnt[15:0]), 32'd0);
        req_vld = 4'b0001;
        nb   = 0;
        done = 1'b0;
        for (int c = 0; c < 90000 && !done; c++) begin
            @(negedge clk); #1;
            if (data_out_vld && data_out_rdy) nb++;
            if (nb >= 65540) done = 1'b1;
        end
        if (!done) chk("st_timeout", 32'(nb), 32'd65540);
        @(negedge clk); #1;
        chk("st_sat", 32'(stats_cnt[15:0]), 32'hFFFF);
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk); #1;
            if (data_out_vld && data_out_rdy) begin
                stats_clr = 1'b1;
                done = 1'b1;
            end
        end
        if (!done) chk("st_clr_timeout", 32'd0, 32'd1);
        @(negedge clk);
        stats_clr = 1'b0;
        #1 chk("st_clr", 32'(stats_cnt[15:0]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
